// File: rtl/keypad_digit_collector.sv
// Keypad digit collector: gathers decoded key presses into a 20-digit BCD word
// and hands it downstream with a one-cycle valid pulse on confirm, skip or exit.

package keypad_pkg;

    // digits[0] is the most recent key; unused positions read as 4'hF
    typedef logic [19:0][3:0] senhaPac_t;

    localparam senhaPac_t SENHA_SKIP = {20{4'hF}};
    localparam senhaPac_t SENHA_EXIT = {20{4'hB}};

    localparam logic [3:0] KEY_CONFIRM   = 4'hA;
    localparam logic [3:0] KEY_EXIT      = 4'hB;
    localparam logic [3:0] KEY_BACKSPACE = 4'hC;

endpackage

module keypad_digit_collector
    import keypad_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned MAX_DIGITS     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] key_value,
    input  logic       key_valid,
    output senhaPac_t  digitos_value,
    output logic       digitos_valid,
    output logic [4:0] digit_count
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]       COUNT_MAX = 5'(MAX_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_EMIT
    } state_e;

    state_e           state_q;
    senhaPac_t        buf_q;
    logic [4:0]       count_q;
    logic             valid_q;
    logic [CNT_W-1:0] idle_cnt_q;

    senhaPac_t shift_in_d;
    senhaPac_t backspace_d;
    logic      is_digit;
    logic      timeout_hit;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        shift_in_d  = {buf_q[18:0], key_value};
        backspace_d = {4'hF, buf_q[19:1]};
        is_digit    = (key_value <= 4'd9);
        timeout_hit = (idle_cnt_q == CNT_LAST);
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            buf_q      <= SENHA_SKIP;
            count_q    <= 5'd0;
            valid_q    <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (!enable) begin
                state_q    <= S_IDLE;
                buf_q      <= SENHA_SKIP;
                count_q    <= 5'd0;
                idle_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        idle_cnt_q <= '0;
                        if (key_valid) begin
                            if (is_digit) begin
                                buf_q   <= shift_in_d;
                                count_q <= 5'd1;
                                state_q <= S_COLLECT;
                            end else if (key_value == KEY_CONFIRM) begin
                                buf_q   <= SENHA_SKIP;
                                count_q <= 5'd0;
                                valid_q <= 1'b1;
                                state_q <= S_EMIT;
                            end else if (key_value == KEY_EXIT) begin
                                buf_q   <= SENHA_EXIT;
                                count_q <= 5'd0;
                                valid_q <= 1'b1;
                                state_q <= S_EMIT;
                            end
                        end
                    end

                    S_COLLECT: begin
                        if (key_valid) begin
                            // Any press, even an ignored one, counts as activity
                            idle_cnt_q <= '0;
                            if (is_digit) begin
                                if (count_q < COUNT_MAX) begin
                                    buf_q   <= shift_in_d;
                                    count_q <= count_q + 5'd1;
                                end
                            end else if (key_value == KEY_CONFIRM) begin
                                valid_q <= 1'b1;
                                state_q <= S_EMIT;
                            end else if (key_value == KEY_EXIT) begin
                                buf_q   <= SENHA_EXIT;
                                count_q <= 5'd0;
                                valid_q <= 1'b1;
                                state_q <= S_EMIT;
                            end else if (key_value == KEY_BACKSPACE) begin
                                buf_q   <= backspace_d;
                                count_q <= count_q - 5'd1;
                                if (count_q == 5'd1) begin
                                    state_q <= S_IDLE;
                                end
                            end
                        end else if (timeout_hit) begin
                            buf_q      <= SENHA_SKIP;
                            count_q    <= 5'd0;
                            idle_cnt_q <= '0;
                            state_q    <= S_IDLE;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end

                    S_EMIT: begin
                        // Keys arriving while the pulse is out are dropped
                        buf_q      <= SENHA_SKIP;
                        count_q    <= 5'd0;
                        idle_cnt_q <= '0;
                        state_q    <= S_IDLE;
                    end

                    default: begin
                        buf_q      <= SENHA_SKIP;
                        count_q    <= 5'd0;
                        idle_cnt_q <= '0;
                        state_q    <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign digitos_value = buf_q;
    assign digitos_valid = valid_q;
    assign digit_count   = count_q;

endmodule
